// File: rtl/sonar_tx_sequencer.sv
// Sends an 8-character "aaa,ddd#" frame built from a snapshot of the BCD angle
// and distance, one character per tx_partida/tx_pronto handshake.
module sonar_tx_sequencer #(
  parameter logic [6:0]  SEPARADOR  = 7'h2C,
  parameter logic [6:0]  TERMINADOR = 7'h23,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [11:0] angulo,
  input  logic [11:0] distancia,
  input  logic        tx_pronto,
  output logic        tx_partida,
  output logic [6:0]  tx_dados,
  output logic        ocupado,
  output logic        fim,
  output logic        erro,
  output logic [3:0]  db_estado,
  output logic [2:0]  db_indice
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    CARREGA = 4'd1,
    PARTIDA = 4'd2,
    ESPERA  = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5,
    ERRO    = 4'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   ang_q, ang_d;
  logic [11:0]   dist_q, dist_d;

  function automatic logic [6:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? {3'b011, d} : 7'h3F;
  endfunction

  function automatic logic [6:0] frame_char(input logic [2:0] idx,
                                            input logic [11:0] a,
                                            input logic [11:0] d);
    logic [6:0] c;
    case (idx)
      3'd0:    c = digit_ascii(a[11:8]);
      3'd1:    c = digit_ascii(a[7:4]);
      3'd2:    c = digit_ascii(a[3:0]);
      3'd3:    c = SEPARADOR;
      3'd4:    c = digit_ascii(d[11:8]);
      3'd5:    c = digit_ascii(d[7:4]);
      3'd6:    c = digit_ascii(d[3:0]);
      default: c = TERMINADOR;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ang_d   = ang_q;
    dist_d  = dist_q;
    case (state_q)
      INICIAL: if (iniciar) state_d = CARREGA;
      CARREGA: begin
        ang_d   = angulo;
        dist_d  = distancia;
        idx_d   = 3'd0;
        state_d = PARTIDA;
      end
      PARTIDA: begin
        cnt_d   = '0;
        state_d = ESPERA;
      end
      // tx_pronto takes priority over an expiring timeout
      ESPERA: begin
        if (tx_pronto)             state_d = PROXIMO;
        else if (cnt_q == CNT_MAX) state_d = ERRO;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      PROXIMO: begin
        if (idx_q == 3'd7) begin
          state_d = FIM;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = PARTIDA;
        end
      end
      // Index returns to 0 so the idle debug view is clean after either ending
      FIM, ERRO: begin
        idx_d   = 3'd0;
        state_d = INICIAL;
      end
      default: begin
        idx_d   = 3'd0;
        state_d = INICIAL;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= INICIAL;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      ang_q      <= 12'd0;
      dist_q     <= 12'd0;
      tx_partida <= 1'b0;
      tx_dados   <= 7'h00;
      ocupado    <= 1'b0;
      fim        <= 1'b0;
      erro       <= 1'b0;
      db_estado  <= 4'd0;
      db_indice  <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ang_q      <= ang_d;
      dist_q     <= dist_d;
      tx_partida <= (state_d == PARTIDA);
      ocupado    <= (state_d != INICIAL);
      fim        <= (state_d == FIM);
      erro       <= (state_d == ERRO);
      db_estado  <= state_d;
      db_indice  <= idx_d;
      if (state_d == PARTIDA || state_d == ESPERA || state_d == PROXIMO)
        tx_dados <= frame_char(idx_d, ang_d, dist_d);
      else
        tx_dados <= 7'h00;
    end
  end

endmodule

// File: tb/tb_sonar_tx_sequencer.sv
// Directed bench for sonar_tx_sequencer: frame content, timing, snapshot,
// ignored starts, timeout and asynchronous reset.
module tb_sonar_tx_sequencer;

  logic        clock;
  logic        reset;
  logic        iniciar;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        tx_pronto;
  logic        tx_partida;
  logic [6:0]  tx_dados;
  logic        ocupado;
  logic        fim;
  logic        erro;
  logic [3:0]  db_estado;
  logic [2:0]  db_indice;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int nfim = 0;
  int nerro = 0;
  int fim_cyc = 0;
  logic [6:0] chars_q[$];

  int resp_w = 5;
  bit hold_en = 0;
  int hold_idx = 0;

  sonar_tx_sequencer #(.TIMEOUT(10)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .angulo(angulo),
    .distancia(distancia), .tx_pronto(tx_pronto), .tx_partida(tx_partida),
    .tx_dados(tx_dados), .ocupado(ocupado), .fim(fim), .erro(erro),
    .db_estado(db_estado), .db_indice(db_indice)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: counts cycles, captures every transmitted character, counts pulses
  initial begin
    forever begin
      @(negedge clock);
      cyc = cyc + 1;
      if (tx_partida === 1'b1) chars_q.push_back(tx_dados);
      if (fim === 1'b1) begin
        nfim = nfim + 1;
        fim_cyc = cyc;
      end
      if (erro === 1'b1) nerro = nerro + 1;
    end
  end

  // Transmitter model: answers each tx_partida with a one-cycle tx_pronto resp_w cycles later
  initial begin
    tx_pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_partida === 1'b1 && !(hold_en && int'(db_indice) == hold_idx)) begin
        for (int i = 0; i < resp_w; i++) @(posedge clock);
        #1 tx_pronto = 1'b1;
        @(posedge clock);
        #1 tx_pronto = 1'b0;
      end
    end
  end

  task automatic start_pulse();
    @(posedge clock);
    #1 iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit expired);
    int n;
    n = 0;
    expired = 1'b1;
    while (n < budget) begin
      @(negedge clock);
      #1;
      n++;
      if (ocupado === 1'b0) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (tx_partida !== 1'b0) begin errors++; $display("FAIL rst_tx_partida got %b want 0", tx_partida); end
    checks++; if (tx_dados !== 7'h00) begin errors++; $display("FAIL rst_tx_dados got %h want 00", tx_dados); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rst_ocupado got %b want 0", ocupado); end
    checks++; if (fim !== 1'b0) begin errors++; $display("FAIL rst_fim got %b want 0", fim); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL rst_erro got %b want 0", erro); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL rst_db_estado got %0d want 0", db_estado); end
    checks++; if (db_indice !== 3'd0) begin errors++; $display("FAIL rst_db_indice got %0d want 0", db_indice); end
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL idle_after_rst got %0d want 0", db_estado); end
  endtask

  task automatic test_normal();
    int base, f0, e0, c0;
    bit to;
    logic [6:0] exp [8];
    logic [6:0] got;
    exp = '{7'h30, 7'h34, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23};
    angulo = 12'h045; distancia = 12'h123; resp_w = 5;
    base = chars_q.size(); f0 = nfim; e0 = nerro;
    start_pulse();
    @(negedge clock); #1 c0 = cyc;
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL normal_carrega got %0d want 1", db_estado); end
    checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL normal_ocupado got %b want 1", ocupado); end
    @(negedge clock); #1;
    checks++; if (tx_partida !== 1'b1) begin errors++; $display("FAIL normal_first_partida got %b want 1", tx_partida); end
    checks++; if (tx_dados !== 7'h30) begin errors++; $display("FAIL normal_first_char got %h want 30", tx_dados); end
    wait_idle(400, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL normal_idle_timeout got %b want 0", to); end
    checks++; if (chars_q.size() - base != 8) begin errors++; $display("FAIL normal_npartida got %0d want 8", chars_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      got = (base + i < chars_q.size()) ? chars_q[base + i] : 7'h7F;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL normal_char%0d got %h want %h", i, got, exp[i]); end
    end
    checks++; if (nfim - f0 != 1) begin errors++; $display("FAIL normal_fim_count got %0d want 1", nfim - f0); end
    checks++; if (nerro - e0 != 0) begin errors++; $display("FAIL normal_erro_count got %0d want 0", nerro - e0); end
    checks++; if (fim_cyc - c0 != 57) begin errors++; $display("FAIL normal_latency got %0d want 57", fim_cyc - c0); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL normal_end_state got %0d want 0", db_estado); end
  endtask

  task automatic test_snapshot();
    int base;
    bit to;
    logic [6:0] exp [3];
    logic [6:0] got;
    exp = '{7'h30, 7'h34, 7'h35};
    angulo = 12'h045; distancia = 12'h123; resp_w = 5;
    base = chars_q.size();
    start_pulse();
    @(posedge clock);
    @(posedge clock);
    #1 angulo = 12'h999;
    wait_idle(400, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL snap_idle_timeout got %b want 0", to); end
    for (int i = 0; i < 3; i++) begin
      got = (base + i < chars_q.size()) ? chars_q[base + i] : 7'h7F;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL snap_char%0d got %h want %h", i, got, exp[i]); end
    end
    angulo = 12'h045;
  endtask

  task automatic test_invalid_digit();
    int base;
    bit to;
    logic [6:0] exp [3];
    logic [6:0] got;
    exp = '{7'h31, 7'h3F, 7'h33};
    angulo = 12'h045; distancia = 12'h1A3; resp_w = 5;
    base = chars_q.size();
    start_pulse();
    wait_idle(400, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL inv_idle_timeout got %b want 0", to); end
    for (int i = 0; i < 3; i++) begin
      got = (base + 4 + i < chars_q.size()) ? chars_q[base + 4 + i] : 7'h7F;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL inv_char%0d got %h want %h", i + 4, got, exp[i]); end
    end
    distancia = 12'h123;
  endtask

  task automatic test_ignored_start();
    int base, f0, n;
    bit to;
    angulo = 12'h045; distancia = 12'h123; resp_w = 5;
    base = chars_q.size(); f0 = nfim;
    start_pulse();
    repeat (20) @(posedge clock);
    #1 iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
    wait_idle(400, to);
    repeat (5) @(negedge clock);
    #1;
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL ign_still_busy got %b want 0", ocupado); end
    checks++; if (nfim - f0 != 1) begin errors++; $display("FAIL ign_fim_count got %0d want 1", nfim - f0); end
    checks++; if (chars_q.size() - base != 8) begin errors++; $display("FAIL ign_npartida got %0d want 8", chars_q.size() - base); end

    f0 = nfim;
    @(posedge clock);
    #1 iniciar = 1'b1;
    n = 0;
    do begin
      @(negedge clock); #1; n++;
    end while (fim !== 1'b1 && n < 200);
    checks++; if (fim !== 1'b1) begin errors++; $display("FAIL hold_fim_seen got %b want 1", fim); end
    @(negedge clock); #1;
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL hold_gap_state got %0d want 0", db_estado); end
    @(negedge clock); #1;
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL hold_restart_state got %0d want 1", db_estado); end
    iniciar = 1'b0;
    wait_idle(400, to);
    checks++; if (nfim - f0 != 2) begin errors++; $display("FAIL hold_fim_count got %0d want 2", nfim - f0); end
  endtask

  task automatic test_timeout();
    int base, f0, e0, n, pc, ec, c0;
    bit to;
    angulo = 12'h045; distancia = 12'h123; resp_w = 5;
    hold_en = 1; hold_idx = 2;
    f0 = nfim; e0 = nerro;
    start_pulse();
    n = 0;
    do begin
      @(negedge clock); #1; n++;
    end while (!(tx_partida === 1'b1 && db_indice === 3'd2) && n < 200);
    pc = cyc;
    checks++; if (db_indice !== 3'd2) begin errors++; $display("FAIL tmo_third_partida got %0d want 2", db_indice); end
    n = 0;
    do begin
      @(negedge clock); #1; n++;
    end while (erro !== 1'b1 && n < 50);
    ec = cyc;
    checks++; if (ec - pc != 11) begin errors++; $display("FAIL tmo_erro_delay got %0d want 11", ec - pc); end
    @(negedge clock); #1;
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL tmo_erro_width got %b want 0", erro); end
    checks++; if (db_indice !== 3'd0) begin errors++; $display("FAIL tmo_indice_after got %0d want 0", db_indice); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL tmo_state_after got %0d want 0", db_estado); end
    checks++; if (nfim - f0 != 0) begin errors++; $display("FAIL tmo_fim_count got %0d want 0", nfim - f0); end
    checks++; if (nerro - e0 != 1) begin errors++; $display("FAIL tmo_erro_count got %0d want 1", nerro - e0); end
    hold_en = 0;
    repeat (10) @(negedge clock);

    resp_w = 10;
    base = chars_q.size(); f0 = nfim; e0 = nerro;
    start_pulse();
    @(negedge clock); #1 c0 = cyc;
    wait_idle(400, to);
    checks++; if (nerro - e0 != 0) begin errors++; $display("FAIL last_cycle_erro got %0d want 0", nerro - e0); end
    checks++; if (nfim - f0 != 1) begin errors++; $display("FAIL last_cycle_fim got %0d want 1", nfim - f0); end
    checks++; if (chars_q.size() - base != 8) begin errors++; $display("FAIL last_cycle_npartida got %0d want 8", chars_q.size() - base); end
    checks++; if (fim_cyc - c0 != 97) begin errors++; $display("FAIL last_cycle_latency got %0d want 97", fim_cyc - c0); end
    resp_w = 5;
  endtask

  task automatic test_reset_mid();
    int f0, e0, n;
    bit to;
    angulo = 12'h045; distancia = 12'h123; resp_w = 5;
    f0 = nfim; e0 = nerro;
    start_pulse();
    n = 0;
    do begin
      @(negedge clock); #1; n++;
    end while (!(tx_partida === 1'b1 && db_indice === 3'd4) && n < 200);
    reset = 1'b0;
    #1;
    checks++; if (tx_partida !== 1'b0) begin errors++; $display("FAIL midrst_tx_partida got %b want 0", tx_partida); end
    checks++; if (tx_dados !== 7'h00) begin errors++; $display("FAIL midrst_tx_dados got %h want 00", tx_dados); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL midrst_ocupado got %b want 0", ocupado); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL midrst_db_estado got %0d want 0", db_estado); end
    checks++; if (db_indice !== 3'd0) begin errors++; $display("FAIL midrst_db_indice got %0d want 0", db_indice); end
    repeat (12) @(negedge clock);
    #1 reset = 1'b1;
    checks++; if (nfim - f0 != 0 || nerro - e0 != 0) begin errors++; $display("FAIL midrst_no_pulse got fim %0d erro %0d want 0 0", nfim - f0, nerro - e0); end
    start_pulse();
    @(negedge clock); #1;
    @(negedge clock); #1;
    checks++; if (tx_partida !== 1'b1 || db_indice !== 3'd0) begin errors++; $display("FAIL midrst_restart got partida %b idx %0d want 1 0", tx_partida, db_indice); end
    checks++; if (tx_dados !== 7'h30) begin errors++; $display("FAIL midrst_restart_char got %h want 30", tx_dados); end
    wait_idle(400, to);
    checks++; if (nfim - f0 != 1) begin errors++; $display("FAIL midrst_fim_count got %0d want 1", nfim - f0); end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; angulo = 12'h000; distancia = 12'h000;
    test_reset();
    test_normal();
    test_snapshot();
    test_invalid_digit();
    test_ignored_start();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonar_tx_sequencer.md
# sonar_tx_sequencer

Controller for the sonar's shared serial transmitter. On a start pulse it snapshots the current BCD angle and distance and sends an 8-character ASCII frame, "aaa,ddd#", one character at a time. It handshakes with the character-level transmitter through `tx_partida` and `tx_pronto`. It sits between the sonar control unit, which raises `iniciar` and waits for `fim`/`erro`, and the serial TX datapath.

## Interface
- `SEPARADOR`, default 7'h2C (','): ASCII sent at frame index 3.
- `TERMINADOR`, default 7'h23 ('#'): ASCII sent at frame index 7.
- `TIMEOUT`, default 100000: cycles to wait for `tx_pronto` before aborting; ≥2.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low; forces INICIAL and clears all registers.
- `iniciar` in 1: start request, sampled only in INICIAL.
- `angulo` in 12: 3 BCD digits, [11:8] hundreds, [7:4] tens, [3:0] units.
- `distancia` in 12: 3 BCD digits, same layout.
- `tx_pronto` in 1: transmitter finished the current character; may be a pulse or a level.
- `tx_partida` out 1: one-cycle start pulse for the transmitter.
- `tx_dados` out 7: ASCII character being sent.
- `ocupado` out 1: high in every state except INICIAL.
- `fim` out 1: one-cycle pulse, frame completed.
- `erro` out 1: one-cycle pulse, frame aborted by timeout.
- `db_estado` out 4: state code.
- `db_indice` out 3: current character index.

## Operation
- States and codes: INICIAL 0, CARREGA 1, PARTIDA 2, ESPERA 3, PROXIMO 4, FIM 5, ERRO 6. Codes 7–15 are unused and any of them returns to INICIAL.
- INICIAL: when `iniciar`=1, go to CARREGA. Otherwise stay.
- CARREGA: register `angulo` and `distancia` into snapshot registers. Clear the index to 0. Go to PARTIDA.
- PARTIDA: `tx_partida`=1. Clear the timeout counter. Go to ESPERA.
- ESPERA: if `tx_pronto`=1, go to PROXIMO. Otherwise, if the timeout counter has reached TIMEOUT-1, go to ERRO. Otherwise increment the counter and stay.
- PROXIMO: if the index is 7, go to FIM. Otherwise increment the index and go to PARTIDA.
- FIM: `fim`=1, then go to INICIAL.
- ERRO: `erro`=1, then go to INICIAL.
- Character map, driven from the snapshot only:
  - index 0–2: angle hundreds, tens, units.
  - index 3: SEPARADOR.
  - index 4–6: distance hundreds, tens, units.
  - index 7: TERMINADOR.
- Digit encoding: a digit d ≤ 9 is sent as {3'b011, d}, i.e. 7'h30+d. A digit > 9 is sent as 7'h3F ('?').
- `tx_dados` follows the index in PARTIDA, ESPERA and PROXIMO. It is 7'h00 in INICIAL, CARREGA, FIM and ERRO.
- All outputs are Moore outputs, decoded from the state register and the index register.

## Timing
- Reset values: state INICIAL, index 0, timeout counter 0, snapshot 0. All outputs are 0: `tx_partida`, `tx_dados`, `ocupado`, `fim`, `erro`, `db_estado`, `db_indice`.
- If `iniciar` is sampled high at edge E0:
  - CARREGA runs during E0–E1.
  - `tx_partida` is high during E1–E2 with `tx_dados` = angle hundreds.
- If `tx_pronto` is sampled high at edge Ek in ESPERA:
  - PROXIMO runs during Ek–Ek+1.
  - The next `tx_partida` is high during Ek+1–Ek+2.
- Frame length: with each `tx_pronto` arriving w cycles after its `tx_partida` (w ≥ 1), the frame takes 1 + 8·(w+2) cycles from E0 until `fim` rises. `fim` is high for exactly one cycle.
- `tx_dados` is stable from the `tx_partida` cycle until PROXIMO ends.
- Ignored inputs:
  - `iniciar` while `ocupado`=1: ignored, not queued.
  - `iniciar` held high: starts a new frame on the first edge back in INICIAL, after `fim`/`erro`.
  - `tx_pronto` outside ESPERA, including the `tx_partida` cycle: ignored.
- `tx_pronto` and timeout in the same cycle: `tx_pronto` wins.
- Input changes after CARREGA have no effect on the frame in progress.
- Reset low mid-frame: everything clears immediately (asynchronous). No `fim` or `erro` is produced. The transmitter is responsible for its own abort.

## Test plan
- Normal frame: angulo=12'h045, distancia=12'h123, `tx_pronto` pulsed 5 cycles after each `tx_partida`. Required: 8 `tx_partida` pulses carrying 30,34,35,2C,31,32,33,23 (hex); `fim` 1 cycle, 57 cycles after E0; `ocupado` falls with return to INICIAL.
- Snapshot: change angulo to 12'h999 two cycles after `iniciar`. Required: the frame still sends 0,4,5.
- Invalid digit: distancia=12'h1A3. Required: index 5 sends 7'h3F.
- Ignored start: pulse `iniciar` mid-frame. Required: one frame only, one `fim`. Hold `iniciar` high: a second frame starts 1 cycle after `fim`.
- Timeout with TIMEOUT=10: withhold `tx_pronto` at index 2. Required: `erro` 1 cycle, 11 cycles after the third `tx_partida`; no `fim`; `db_indice`=0 afterwards. `tx_pronto` on the final counter cycle: PROXIMO, no `erro`.
- Reset mid-frame: pull `reset` low at index 4. Required: all outputs 0 immediately (`db_estado`=0, `db_indice`=0); the next `iniciar` starts a normal frame at index 0.
